// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the memory-handshake state encoding and the register-match helper.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // r0 is hardwired to zero, so it can never carry a true dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dest);
    return (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = pipeline side (drives operand/stage info), slave = controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       src1;
  logic [4:0]       src2;
  logic             two_regs;
  logic [4:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [4:0]       mem_dest;
  logic             mem_wb_en;
  logic             fwd_en;
  logic             branch_taken;
  logic             mem_access;
  logic             sram_ready;
  logic             freez_front;
  logic             freez_back;
  logic             flush_ifid;
  logic             flush_idexe;
  logic             sram_start;
  logic             mem_error;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output src1, src2, two_regs, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_access, sram_ready,
    input  freez_front, freez_back, flush_ifid, flush_idexe, sram_start,
           mem_error, stall_count
  );

  modport slave (
    input  src1, src2, two_regs, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_access, sram_ready,
    output freez_front, freez_back, flush_ifid, flush_idexe, sram_start,
           mem_error, stall_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detector between the ID stage and EXE/MEM.
// With forwarding only a load-use in EXE needs a stall.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       two_regs,
  input  logic [4:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_read,
  input  logic [4:0] mem_dest,
  input  logic       mem_wb_en,
  input  logic       fwd_en,
  output logic       hazard
);

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = reg_match(src1, exe_dest) | (two_regs & reg_match(src2, exe_dest));
  assign mem_hit = reg_match(src1, mem_dest) | (two_regs & reg_match(src2, mem_dest));

  assign hazard = fwd_en ? (exe_wb_en & exe_mem_read & exe_hit)
                         : ((exe_wb_en & exe_hit) | (mem_wb_en & mem_hit));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: data-hazard stalls, branch squash and
// the multi-cycle SRAM handshake that freezes the whole pipeline.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e      state;
  logic [WCNT_W-1:0] wait_cnt;
  logic             sram_start_q;
  logic             mem_error_q;
  logic [CNT_W-1:0] stall_cnt;

  logic hazard;
  logic timeout_hit;
  logic mem_stall;
  logic freez_front_c;
  logic freez_back_c;
  logic flush_ifid_c;
  logic flush_idexe_c;

  hazard_detect u_hazard_detect (
    .src1         (bus.src1),
    .src2         (bus.src2),
    .two_regs     (bus.two_regs),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_read (bus.exe_mem_read),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .fwd_en       (bus.fwd_en),
    .hazard       (hazard)
  );

  // A ready in the last wait cycle is a normal completion, not a timeout.
  assign timeout_hit = (state == WAIT) && !bus.sram_ready && (wait_cnt == WCNT_LAST);
  assign mem_stall   = ((state == RUN) && bus.mem_access) ||
                       ((state == WAIT) && !bus.sram_ready && !timeout_hit);

  // NOTE: every output gets a default first so no path leaves a value held (no latch).
  always_comb begin
    freez_front_c = 1'b0;
    freez_back_c  = 1'b0;
    flush_ifid_c  = 1'b0;
    flush_idexe_c = 1'b0;
    if (mem_stall) begin
      freez_front_c = 1'b1;
      freez_back_c  = 1'b1;
    end else if (bus.branch_taken) begin
      flush_ifid_c  = 1'b1;
      flush_idexe_c = 1'b1;
    end else if (hazard) begin
      freez_front_c = 1'b1;
      flush_idexe_c = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      sram_start_q <= 1'b0;
      mem_error_q  <= 1'b0;
    end else begin
      sram_start_q <= 1'b0;
      case (state)
        RUN: begin
          if (bus.mem_access) begin
            state        <= WAIT;
            wait_cnt     <= '0;
            sram_start_q <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.sram_ready) begin
            state <= RUN;
          end else if (timeout_hit) begin
            state       <= RUN;
            mem_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (freez_front_c && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.freez_front = freez_front_c;
  assign bus.freez_back  = freez_back_c;
  assign bus.flush_ifid  = flush_ifid_c;
  assign bus.flush_idexe = flush_idexe_c;
  assign bus.sram_start  = sram_start_q;
  assign bus.mem_error   = mem_error_q;
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a default controller plus a short-timeout, narrow-counter
// copy driven with the same inputs for the timeout and saturation cases.
module tb_pipeline_hazard_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  bus_t ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) u_dut_t (
    .clock (clock),
    .reset (reset),
    .bus   (bus_t)
  );

  assign bus_t.src1         = bus.src1;
  assign bus_t.src2         = bus.src2;
  assign bus_t.two_regs     = bus.two_regs;
  assign bus_t.exe_dest     = bus.exe_dest;
  assign bus_t.exe_wb_en    = bus.exe_wb_en;
  assign bus_t.exe_mem_read = bus.exe_mem_read;
  assign bus_t.mem_dest     = bus.mem_dest;
  assign bus_t.mem_wb_en    = bus.mem_wb_en;
  assign bus_t.fwd_en       = bus.fwd_en;
  assign bus_t.branch_taken = bus.branch_taken;
  assign bus_t.mem_access   = bus.mem_access;
  assign bus_t.sram_ready   = bus.sram_ready;

  initial clock = 1'b0;
  always #25 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.src1         = 5'd0;
    bus.src2         = 5'd0;
    bus.two_regs     = 1'b0;
    bus.exe_dest     = 5'd0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_read = 1'b0;
    bus.mem_dest     = 5'd0;
    bus.mem_wb_en    = 1'b0;
    bus.fwd_en       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_access   = 1'b0;
    bus.sram_ready   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    #2 reset = 1'b0;
    #1;
    check("rst_stall_count", bus.stall_count, 32'd0);
    check("rst_mem_error", {31'd0, bus.mem_error}, 32'd0);
    check("rst_sram_start", {31'd0, bus.sram_start}, 32'd0);
    check("rst_freez_front", {31'd0, bus.freez_front}, 32'd0);

    @(negedge clock);
    reset = 1'b1;

    // Combinational hazard cases, all inside one low clock phase.
    bus.src1 = 5'd3; bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b1;
    #1;
    check("raw_exe_freez_front", {31'd0, bus.freez_front}, 32'd1);
    check("raw_exe_flush_idexe", {31'd0, bus.flush_idexe}, 32'd1);
    check("raw_exe_freez_back", {31'd0, bus.freez_back}, 32'd0);
    check("raw_exe_flush_ifid", {31'd0, bus.flush_ifid}, 32'd0);

    bus.exe_dest = 5'd0;
    #1;
    check("raw_r0_freez_front", {31'd0, bus.freez_front}, 32'd0);
    check("raw_r0_flush_idexe", {31'd0, bus.flush_idexe}, 32'd0);

    bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b0; bus.mem_dest = 5'd3; bus.mem_wb_en = 1'b1;
    #1;
    check("raw_mem_freez_front", {31'd0, bus.freez_front}, 32'd1);

    bus.fwd_en = 1'b1;
    #1;
    check("fwd_mem_freez_front", {31'd0, bus.freez_front}, 32'd0);

    bus.src1 = 5'd1; bus.src2 = 5'd5; bus.two_regs = 1'b1;
    bus.exe_dest = 5'd5; bus.exe_wb_en = 1'b1; bus.exe_mem_read = 1'b1;
    bus.mem_dest = 5'd0; bus.mem_wb_en = 1'b0;
    #1;
    check("load_use_freez_front", {31'd0, bus.freez_front}, 32'd1);
    check("load_use_flush_idexe", {31'd0, bus.flush_idexe}, 32'd1);

    bus.two_regs = 1'b0;
    #1;
    check("load_use_one_reg", {31'd0, bus.freez_front}, 32'd0);

    bus.two_regs = 1'b1; bus.exe_mem_read = 1'b0;
    #1;
    check("fwd_alu_no_stall", {31'd0, bus.freez_front}, 32'd0);

    bus.exe_mem_read = 1'b1; bus.branch_taken = 1'b1;
    #1;
    check("branch_hz_flush_ifid", {31'd0, bus.flush_ifid}, 32'd1);
    check("branch_hz_flush_idexe", {31'd0, bus.flush_idexe}, 32'd1);
    check("branch_hz_freez_front", {31'd0, bus.freez_front}, 32'd0);

    // Load-use held across two rising edges.
    bus.branch_taken = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("hazard_stall_count", bus.stall_count, 32'd2);
    clear_inputs();

    // SRAM access, ready three cycles after the start pulse.
    bus.mem_access = 1'b1;
    #1;
    check("mem_run_freez_front", {31'd0, bus.freez_front}, 32'd1);
    check("mem_run_freez_back", {31'd0, bus.freez_back}, 32'd1);
    check("mem_run_flush_idexe", {31'd0, bus.flush_idexe}, 32'd0);
    check("mem_run_sram_start", {31'd0, bus.sram_start}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check("mem_wait_freez_back", {31'd0, bus.freez_back}, 32'd1);
      check("mem_wait_sram_start", {31'd0, bus.sram_start}, (k == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    bus.sram_ready = 1'b1;
    #1;
    check("mem_ready_freez_back", {31'd0, bus.freez_back}, 32'd0);
    check("mem_ready_freez_front", {31'd0, bus.freez_front}, 32'd0);
    @(negedge clock);
    clear_inputs();
    #1;
    check("mem_stall_count", bus.stall_count, 32'd6);
    check("mem_no_error", {31'd0, bus.mem_error}, 32'd0);
    check("mem_start_done", {31'd0, bus.sram_start}, 32'd0);

    // Branch resolved while the pipeline is frozen on memory.
    bus.mem_access = 1'b1;
    @(negedge clock);
    bus.branch_taken = 1'b1;
    #1;
    check("br_wait_flush_ifid", {31'd0, bus.flush_ifid}, 32'd0);
    check("br_wait_flush_idexe", {31'd0, bus.flush_idexe}, 32'd0);
    check("br_wait_freez_back", {31'd0, bus.freez_back}, 32'd1);
    @(negedge clock);
    check("br_wait2_flush_ifid", {31'd0, bus.flush_ifid}, 32'd0);
    bus.sram_ready = 1'b1;
    #1;
    check("br_release_flush_ifid", {31'd0, bus.flush_ifid}, 32'd1);
    check("br_release_flush_idexe", {31'd0, bus.flush_idexe}, 32'd1);
    check("br_release_freez_back", {31'd0, bus.freez_back}, 32'd0);
    check("br_release_freez_front", {31'd0, bus.freez_front}, 32'd0);
    @(negedge clock);
    clear_inputs();
    #1;
    check("br_stall_count", bus.stall_count, 32'd8);

    reset = 1'b0;
    #5 reset = 1'b1;

    // Timeout on the MEM_TIMEOUT=4 controller.
    bus.mem_access = 1'b1;
    @(negedge clock);
    check("to_w0_sram_start", {31'd0, bus_t.sram_start}, 32'd1);
    check("to_w0_freez_back", {31'd0, bus_t.freez_back}, 32'd1);
    @(negedge clock);
    check("to_w1_freez_back", {31'd0, bus_t.freez_back}, 32'd1);
    @(negedge clock);
    check("to_w2_freez_back", {31'd0, bus_t.freez_back}, 32'd1);
    @(negedge clock);
    check("to_w3_freez_back", {31'd0, bus_t.freez_back}, 32'd0);
    check("to_w3_freez_front", {31'd0, bus_t.freez_front}, 32'd0);
    check("to_w3_mem_error", {31'd0, bus_t.mem_error}, 32'd0);
    @(negedge clock);
    check("to_run_mem_error", {31'd0, bus_t.mem_error}, 32'd1);
    check("to_stall_count", {29'd0, bus_t.stall_count}, 32'd4);
    bus.mem_access = 1'b0;
    #1;
    check("to_run_freez_front", {31'd0, bus_t.freez_front}, 32'd0);

    // Five more stall cycles push the 3-bit counter past its maximum.
    bus.src1 = 5'd3; bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b1;
    repeat (5) @(negedge clock);
    check("sat_stall_count", {29'd0, bus_t.stall_count}, 32'd7);
    check("sticky_mem_error", {31'd0, bus_t.mem_error}, 32'd1);
    clear_inputs();
    #1;
    check("pre_reset_wait", {31'd0, bus.freez_back}, 32'd1);

    // Asynchronous reset while the default controller is still in WAIT.
    #4 reset = 1'b0;
    #1;
    check("async_rst_freez_back", {31'd0, bus.freez_back}, 32'd0);
    check("async_rst_stall_count", bus.stall_count, 32'd0);
    check("async_rst_sram_start", {31'd0, bus.sram_start}, 32'd0);
    check("async_rst_mem_error", {31'd0, bus_t.mem_error}, 32'd0);
    check("async_rst_t_stall", {29'd0, bus_t.stall_count}, 32'd0);
    #5 reset = 1'b1;
    @(negedge clock);
    check("post_rst_sram_start", {31'd0, bus.sram_start}, 32'd0);
    check("post_rst_freez_back", {31'd0, bus.freez_back}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
